// File: rtl/asteroides_pkg.sv
// ---------------------------------------------------------------------------
// asteroides_pkg
//
// Definitions shared by the asteroid spawn controller and the movement stage.
//   - estado_t      : state encodings of the spawn controller (values are the
//                     debug codes shown on db_estado_gera_aste)
//   - DB_INVALIDO   : debug code shown for any unused state encoding
//   - OP_HC/OP_HD/OP_VC/OP_VD : asteroid direction opcodes
//   - LFSR_TAPS     : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - palavra_*     : bit offsets of the fields inside an asteroid word
//                     {loaded, opcode[1:0], x[COORD_W-1:0], y[COORD_W-1:0]}
// ---------------------------------------------------------------------------
package asteroides_pkg;

    typedef enum logic [4:0] {
        INICIO          = 5'd0,
        ESPERA          = 5'd1,
        RESETA_CONTADOR = 5'd2,
        VERIFICA_LOADED = 5'd3,
        INCREMENTA      = 5'd4,
        ESCREVE         = 5'd5,
        SINALIZA        = 5'd6,
        CHEIO           = 5'd7
    } estado_t;

    localparam logic [4:0] DB_INVALIDO = 5'b11111;

    // Direction opcodes: horizontal/vertical, crescente/decrescente
    localparam logic [1:0] OP_HC = 2'b00;
    localparam logic [1:0] OP_HD = 2'b01;
    localparam logic [1:0] OP_VC = 2'b10;
    localparam logic [1:0] OP_VD = 2'b11;

    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Field offsets of the asteroid word, for a given coordinate width
    function automatic int palavra_y_lsb(input int coord_w);
        palavra_y_lsb = 0;
    endfunction

    function automatic int palavra_x_lsb(input int coord_w);
        palavra_x_lsb = coord_w;
    endfunction

    function automatic int palavra_op_lsb(input int coord_w);
        palavra_op_lsb = 2 * coord_w;
    endfunction

    function automatic int palavra_loaded_bit(input int coord_w);
        palavra_loaded_bit = 2 * coord_w + 2;
    endfunction

    function automatic int palavra_largura(input int coord_w);
        palavra_largura = 2 * coord_w + 3;
    endfunction

endpackage

// File: rtl/uc_gera_asteroides_lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8
//
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting
// left once per clock. The feedback bit enters at bit 0.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous active-low reset, loads SEMENTE
//   valor  out  current LFSR state
//
// Parameter SEMENTE must be nonzero, otherwise the register locks at zero.
// ---------------------------------------------------------------------------
module lfsr8
    import asteroides_pkg::*;
#(
    parameter logic [7:0] SEMENTE = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] valor
);

    // Feedback is the XOR of the tapped bits (7,5,4,3)
    always_ff @(posedge clock) begin
        if (!reset) begin
            valor <= SEMENTE;
        end else begin
            valor <= {valor[6:0], ^(valor & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/uc_gera_asteroides.sv
// ---------------------------------------------------------------------------
// uc_gera_asteroides
//
// Asteroid spawn controller. On each request it scans the asteroid memory
// from slot 0 for the first slot whose loaded bit is clear and writes a new
// asteroid word there. Direction and edge position come from a sample of an
// internal LFSR taken at the start of the request. If every slot is loaded
// it finishes with a "memory full" indication instead.
//
// Ports:
//   clock               in   system clock, rising edge
//   reset               in   synchronous active-low reset
//   gera_aste           in   spawn request, only looked at in ESPERA
//   loaded_aste         in   loaded bit of the slot at endereco_aste
//   endereco_aste       out  slot address (the scan counter)
//   enable_mem_aste     out  one-cycle memory write enable
//   dado_aste           out  {loaded, opcode[1:0], x, y}, zero unless writing
//   geracao_concluida   out  one-cycle pulse at the end of every request
//   sem_espaco          out  one-cycle pulse with geracao_concluida when full
//   db_estado_gera_aste out  current state code (5'b11111 for unused codes)
//   db_amostra          out  LFSR sample register (only with the macro below)
//
// Configuration macro:
//   GERA_ASTE_DB_AMOSTRA_EN  adds the db_amostra debug output port.
//
// All outputs except db_estado_gera_aste are registered: they are loaded on
// the same edge that enters the state in which they are asserted, so they
// line up exactly with the state register.
// ---------------------------------------------------------------------------
module uc_gera_asteroides #(
    parameter int         N_ASTE  = 16,
    parameter int         ADDR_W  = 4,
    parameter int         COORD_W = 4,
    parameter logic [7:0] SEMENTE = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 gera_aste,
    input  logic                 loaded_aste,
    output logic [ADDR_W-1:0]    endereco_aste,
    output logic                 enable_mem_aste,
    output logic [2+2*COORD_W:0] dado_aste,
    output logic                 geracao_concluida,
    output logic                 sem_espaco,
    output logic [4:0]           db_estado_gera_aste
`ifdef GERA_ASTE_DB_AMOSTRA_EN
    ,
    output logic [7:0]           db_amostra
`endif
);

    import asteroides_pkg::*;

    localparam int PAL_W      = palavra_largura(COORD_W);
    localparam int Y_LSB      = palavra_y_lsb(COORD_W);
    localparam int X_LSB      = palavra_x_lsb(COORD_W);
    localparam int OP_LSB     = palavra_op_lsb(COORD_W);
    localparam int LOADED_BIT = palavra_loaded_bit(COORD_W);

    localparam logic [ADDR_W-1:0]  ULTIMO_SLOT = ADDR_W'(N_ASTE - 1);
    localparam logic [COORD_W-1:0] COORD_MAX   = '1;

    estado_t             estado;
    logic [ADDR_W-1:0]   contador;
    logic [7:0]          amostra;
    logic [7:0]          lfsr_valor;

    logic [1:0]          op_novo;
    logic [COORD_W-1:0]  r_novo;
    logic [COORD_W-1:0]  x_novo;
    logic [COORD_W-1:0]  y_novo;
    logic [PAL_W-1:0]    palavra_nova;

    // Random source, runs every cycle regardless of the state machine
    lfsr8 #(
        .SEMENTE (SEMENTE)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .valor (lfsr_valor)
    );

    // Opcode in the two low bits of the sample, the edge offset r right above
    assign op_novo = amostra[1:0];
    assign r_novo  = COORD_W'(amostra >> 2);

    // The asteroid enters on the edge opposite to its direction of travel,
    // at offset r along that edge
    always_comb begin
        x_novo = '0;
        y_novo = '0;
        case (op_novo)
            OP_HC: begin
                x_novo = '0;
                y_novo = r_novo;
            end
            OP_HD: begin
                x_novo = COORD_MAX;
                y_novo = r_novo;
            end
            OP_VC: begin
                x_novo = r_novo;
                y_novo = '0;
            end
            OP_VD: begin
                x_novo = r_novo;
                y_novo = COORD_MAX;
            end
            default: begin
                x_novo = '0;
                y_novo = '0;
            end
        endcase
    end

    // Assemble the new word from the package field offsets
    always_comb begin
        palavra_nova                        = '0;
        palavra_nova[LOADED_BIT]            = 1'b1;
        palavra_nova[OP_LSB +: 2]           = op_novo;
        palavra_nova[X_LSB +: COORD_W]      = x_novo;
        palavra_nova[Y_LSB +: COORD_W]      = y_novo;
    end

    // Control FSM with registered outputs. Pulse outputs default to zero each
    // cycle and are set only on the transition into the state that owns them.
    // The counter is compared against the last slot before incrementing, so
    // a full scan stops at N_ASTE-1 instead of wrapping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado            <= INICIO;
            contador          <= '0;
            amostra           <= '0;
            enable_mem_aste   <= 1'b0;
            dado_aste         <= '0;
            geracao_concluida <= 1'b0;
            sem_espaco        <= 1'b0;
        end else begin
            enable_mem_aste   <= 1'b0;
            dado_aste         <= '0;
            geracao_concluida <= 1'b0;
            sem_espaco        <= 1'b0;

            case (estado)
                INICIO: begin
                    estado <= ESPERA;
                end

                ESPERA: begin
                    if (gera_aste) begin
                        estado <= RESETA_CONTADOR;
                    end
                end

                RESETA_CONTADOR: begin
                    contador <= '0;
                    amostra  <= lfsr_valor;
                    estado   <= VERIFICA_LOADED;
                end

                VERIFICA_LOADED: begin
                    if (!loaded_aste) begin
                        estado          <= ESCREVE;
                        enable_mem_aste <= 1'b1;
                        dado_aste       <= palavra_nova;
                    end else if (contador == ULTIMO_SLOT) begin
                        estado            <= CHEIO;
                        geracao_concluida <= 1'b1;
                        sem_espaco        <= 1'b1;
                    end else begin
                        estado <= INCREMENTA;
                    end
                end

                INCREMENTA: begin
                    contador <= contador + ADDR_W'(1);
                    estado   <= VERIFICA_LOADED;
                end

                ESCREVE: begin
                    estado            <= SINALIZA;
                    geracao_concluida <= 1'b1;
                end

                SINALIZA, CHEIO: begin
                    estado <= ESPERA;
                end

                default: begin
                    estado <= INICIO;
                end
            endcase
        end
    end

    assign endereco_aste = contador;

`ifdef GERA_ASTE_DB_AMOSTRA_EN
    assign db_amostra = amostra;
`endif

    // Debug code is the state encoding itself; anything outside the defined
    // set is flagged so a corrupted state register is visible
    always_comb begin
        db_estado_gera_aste = DB_INVALIDO;
        case (estado)
            INICIO, ESPERA, RESETA_CONTADOR, VERIFICA_LOADED,
            INCREMENTA, ESCREVE, SINALIZA, CHEIO: begin
                db_estado_gera_aste = estado;
            end
            default: begin
                db_estado_gera_aste = DB_INVALIDO;
            end
        endcase
    end

endmodule

// File: doc/uc_gera_asteroides.md
Name: uc_gera_asteroides

Overview:
- Spawn controller directly upstream of the asteroid-movement stage.
- On each spawn request it scans the asteroid memory for the first free slot (loaded=0) and writes a new asteroid word into it. The written word carries loaded, opcode and edge position, which the movement stage later consumes.
- Randomness comes from an internal free-running 8-bit LFSR.
- Reports done, or "memory full" when no slot is free.

Parameters:
- N_ASTE, 16, number of asteroid memory slots (power of two, ≥2).
- ADDR_W, 4, log2(N_ASTE).
- COORD_W, 4, width of each coordinate (2 ≤ COORD_W ≤ 6).
- SEMENTE, 8'hA5, LFSR reset value (must be nonzero).

Ports:
- clock  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- gera_aste  in  1  spawn request. Sampled only in ESPERA.
- loaded_aste  in  1  loaded bit of the slot at endereco_aste (asynchronous memory read).
- endereco_aste  out  ADDR_W  slot address. Equals the scan counter.
- enable_mem_aste  out  1  memory write enable (one cycle).
- dado_aste  out  3+2*COORD_W  word to write: {loaded, opcode[1:0], x, y}. All zeros when enable_mem_aste=0.
- geracao_concluida  out  1  one-cycle pulse when the request finishes (spawned or full).
- sem_espaco  out  1  one-cycle pulse, coincident with geracao_concluida, when no slot is free.
- db_estado_gera_aste  out  5  current state code.

Behaviour:
- Reset: when reset=0 at a clock edge:
  - state becomes INICIO; scan counter, amostra and all outputs go to 0.
  - LFSR loads SEMENTE.
  - A reset in the middle of a scan aborts it: no write and no completion pulse.
- LFSR:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting left every cycle when not in reset.
  - Register amostra captures the LFSR value in RESETA_CONTADOR and holds it until the next capture.
- States (Moore machine), with db code in parentheses:
  - INICIO (0) -> ESPERA.
  - ESPERA (1) -> RESETA_CONTADOR if gera_aste=1, otherwise stay.
  - RESETA_CONTADOR (2): counter cleared, amostra captured -> VERIFICA_LOADED.
  - VERIFICA_LOADED (3):
    - loaded_aste=0 -> ESCREVE.
    - loaded_aste=1 and counter=N_ASTE-1 -> CHEIO.
    - otherwise -> INCREMENTA.
  - INCREMENTA (4): counter+1 -> VERIFICA_LOADED.
  - ESCREVE (5): enable_mem_aste=1 -> SINALIZA.
  - SINALIZA (6): geracao_concluida=1 -> ESPERA.
  - CHEIO (7): geracao_concluida=1, sem_espaco=1 -> ESPERA.
  - Unused codes -> INICIO; db code 5'b11111.
- Word content in ESCREVE:
  - loaded=1.
  - opcode=amostra[1:0].
  - r=amostra[COORD_W+1:2].
  - M = 2^COORD_W-1.
  - Position by opcode:
    - 00 (horizontal crescente): x=0, y=r.
    - 01 (horizontal decrescente): x=M, y=r.
    - 10 (vertical crescente): x=r, y=0.
    - 11 (vertical decrescente): x=r, y=M.
- Timing: with gera_aste seen in ESPERA at cycle 0:
  - First free slot k: VERIFICA_LOADED for slot k at cycle 2+2k, write at cycle 3+2k, geracao_concluida at cycle 4+2k.
  - Memory full: CHEIO at cycle 2*N_ASTE+1.
- Boundary conditions:
  - gera_aste is ignored outside ESPERA.
  - gera_aste held high starts a new scan immediately after the pulse state.
  - Only the first free slot is written; at most one write per request.
  - The counter never wraps during a scan.

Optional Feature:
- Macro GERA_ASTE_DB_AMOSTRA_EN.
- Defined: adds output port db_amostra [7:0], equal to the amostra register (reset 0).
- Undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Shared package asteroides_pkg holds:
  - the state encodings;
  - the opcode constants OP_HC=00, OP_HD=01, OP_VC=10, OP_VD=11 (also used by the movement stage);
  - the word field offsets.
- One natural sub-module: lfsr8 (clock, reset, seed parameter, 8-bit out).

Test Plan:
- Reset, then pulse gera_aste with all 4 slots free (N_ASTE=4) -> write to address 0 at cycle 3; geracao_concluida=1 at cycle 4; sem_espaco=0.
- Slots 0 and 1 loaded, slots 2 and 3 free -> single write to address 2 at cycle 7; concluida at cycle 8; no write to address 3.
- All 4 slots loaded -> no enable_mem_aste pulse; concluida=1 and sem_espaco=1 together at cycle 9.
- With GERA_ASTE_DB_AMOSTRA_EN, amostra=8'b00101101 (opcode 01, r=1011), COORD_W=4 -> dado_aste=11'b1_01_1111_1011.
- Reset=0 asserted during INCREMENTA -> next cycle db=0, then 1; no write and no concluida pulse; LFSR restarts from SEMENTE.
- gera_aste held high for 20 cycles with slots free -> back-to-back requests, one write per request, each separated by one ESPERA cycle; a pulse arriving during a scan is ignored.
